// File: rtl/instr_sequencer.sv
// instr_sequencer: picoMIPS control stage.
// Owns the program counter, decodes the opcode into ALU/datapath controls,
// and stalls the PC for the WAIT0/WAIT1 switch handshake and for
// multi-cycle multiplies.
module instr_sequencer #(
    parameter int P_SIZE     = 4,
    parameter int O_SIZE     = 3,
    parameter int A_SIZE     = 2,
    parameter int PROG_LEN   = 16,
    parameter int MUL_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [O_SIZE-1:0] opcode,
    input  logic              sw8,
    output logic [P_SIZE-1:0] pc,
    output logic [A_SIZE-1:0] alu_func,
    output logic              reg_we,
    output logic              imm_sel,
    output logic              sw_sel,
    output logic              stalled
);

    // Counter holds MUL_CYCLES-2 at most (6 for MUL_CYCLES=8).
    localparam int CNT_W = 3;

    localparam logic [O_SIZE-1:0] OP_LDI   = O_SIZE'(0);
    localparam logic [O_SIZE-1:0] OP_LDS   = O_SIZE'(1);
    localparam logic [O_SIZE-1:0] OP_ADD   = O_SIZE'(2);
    localparam logic [O_SIZE-1:0] OP_ADDI  = O_SIZE'(3);
    localparam logic [O_SIZE-1:0] OP_MUL   = O_SIZE'(4);
    localparam logic [O_SIZE-1:0] OP_MULI  = O_SIZE'(5);
    localparam logic [O_SIZE-1:0] OP_WAIT0 = O_SIZE'(6);
    localparam logic [O_SIZE-1:0] OP_WAIT1 = O_SIZE'(7);

    localparam logic [A_SIZE-1:0] ALU_A   = A_SIZE'(0);
    localparam logic [A_SIZE-1:0] ALU_B   = A_SIZE'(1);
    localparam logic [A_SIZE-1:0] ALU_ADD = A_SIZE'(2);
    localparam logic [A_SIZE-1:0] ALU_MUL = A_SIZE'(3);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_MULT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   mul_cnt_q, mul_cnt_d;
    logic [P_SIZE-1:0]  pc_q, pc_d, pc_inc;
    logic               sync1_q, sync2_q;
    logic               sw8_s;
    logic               we_c, stall_c;

    assign sw8_s = sync2_q;

    // Wrapping increment: PROG_LEN need not be a power of two.
    always_comb begin
        pc_inc = (pc_q == P_SIZE'(PROG_LEN - 1)) ? '0 : pc_q + P_SIZE'(1);
    end

    // Decode and next-state: controls depend on state, opcode, sw8_s, mul_cnt.
    always_comb begin
        alu_func  = ALU_A;
        imm_sel   = 1'b0;
        sw_sel    = 1'b0;
        we_c      = 1'b0;
        stall_c   = 1'b0;
        state_d   = state_q;
        mul_cnt_d = mul_cnt_q;
        unique case (state_q)
            ST_RUN: begin
                case (opcode)
                    OP_LDI: begin
                        alu_func = ALU_B;
                        imm_sel  = 1'b1;
                        we_c     = 1'b1;
                    end
                    OP_LDS: begin
                        alu_func = ALU_B;
                        sw_sel   = 1'b1;
                        we_c     = 1'b1;
                    end
                    OP_ADD: begin
                        alu_func = ALU_ADD;
                        we_c     = 1'b1;
                    end
                    OP_ADDI: begin
                        alu_func = ALU_ADD;
                        imm_sel  = 1'b1;
                        we_c     = 1'b1;
                    end
                    OP_MUL, OP_MULI: begin
                        alu_func = ALU_MUL;
                        imm_sel  = opcode[0];
                        if (MUL_CYCLES == 1) begin
                            we_c = 1'b1;
                        end else begin
                            stall_c   = 1'b1;
                            state_d   = ST_MULT;
                            mul_cnt_d = CNT_W'(MUL_CYCLES - 2);
                        end
                    end
                    OP_WAIT0: begin
                        stall_c = sw8_s;
                    end
                    OP_WAIT1: begin
                        stall_c = ~sw8_s;
                    end
                    default: begin
                    end
                endcase
            end
            ST_MULT: begin
                // PC is held, so opcode still names the multiply in flight.
                alu_func = ALU_MUL;
                imm_sel  = opcode[0];
                if (mul_cnt_q == '0) begin
                    we_c    = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    stall_c   = 1'b1;
                    mul_cnt_d = mul_cnt_q - CNT_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // Reset masks the write/stall strobes; decode outputs stay live.
    always_comb begin
        reg_we  = we_c & ~reset;
        stalled = stall_c & ~reset;
        pc_d    = stall_c ? pc_q : pc_inc;
        pc      = pc_q;
    end

    // State registers: pc, FSM, multiply counter, two-flop sw8 synchronizer.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= '0;
            state_q   <= ST_RUN;
            mul_cnt_q <= '0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
            sync1_q   <= sw8;
            sync2_q   <= sync1_q;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Testbench for instr_sequencer: directed program plus randomized programs,
// switch activity and resets, checked cycle by cycle against a
// behavioural model of the instruction timing rules.
module tb_instr_sequencer;

    localparam int P_SIZE     = 4;
    localparam int O_SIZE     = 3;
    localparam int A_SIZE     = 2;
    localparam int PROG_LEN   = 10;
    localparam int MUL_CYCLES = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [O_SIZE-1:0] opcode;
    logic              sw8;
    logic [P_SIZE-1:0] pc;
    logic [A_SIZE-1:0] alu_func;
    logic              reg_we;
    logic              imm_sel;
    logic              sw_sel;
    logic              stalled;

    instr_sequencer #(
        .P_SIZE    (P_SIZE),
        .O_SIZE    (O_SIZE),
        .A_SIZE    (A_SIZE),
        .PROG_LEN  (PROG_LEN),
        .MUL_CYCLES(MUL_CYCLES)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .opcode  (opcode),
        .sw8     (sw8),
        .pc      (pc),
        .alu_func(alu_func),
        .reg_we  (reg_we),
        .imm_sel (imm_sel),
        .sw_sel  (sw_sel),
        .stalled (stalled)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Program memory image, indexed by the model's pc.
    int prog [PROG_LEN];

    // Model state: expected pc, cycles already spent on the current
    // multiply, and the last two sw8 values sampled at clock edges.
    int m_pc;
    int m_elapsed;
    bit sw_hist_old;
    bit sw_hist_new;

    task automatic check_val(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (pc model %0d, t=%0t)",
                      tag, obs, exp_v, m_pc, $time);
    endtask

    // One clock cycle: drive inputs after the falling edge, compare the
    // combinational outputs, then let the rising edge advance the model.
    task automatic run_cycle(input bit rst, input bit sw, input bit glitch);
        int op;
        int e_alu;
        int e_imm;
        int e_sws;
        int e_we;
        int e_st;
        bit last_mul;
        bit sw_s;
        @(negedge clk);
        reset  = rst;
        op     = prog[m_pc];
        opcode = O_SIZE'(op);
        sw8    = glitch ? ~sw : sw;
        #1;
        sw_s = sw_hist_old;
        if (op <= 1)      e_alu = 1;
        else if (op <= 3) e_alu = 2;
        else if (op <= 5) e_alu = 3;
        else              e_alu = 0;
        e_imm = (op == 0 || op == 3 || op == 5) ? 1 : 0;
        e_sws = (op == 1) ? 1 : 0;
        last_mul = (m_elapsed == MUL_CYCLES - 1);
        if (op == 4 || op == 5) begin
            e_we = last_mul ? 1 : 0;
            e_st = last_mul ? 0 : 1;
        end else if (op >= 6) begin
            e_we = 0;
            e_st = (sw_s == (op == 7)) ? 0 : 1;
        end else begin
            e_we = 1;
            e_st = 0;
        end
        check_val("pc", int'(pc), m_pc);
        check_val("alu_func", int'(alu_func), e_alu);
        if (op < 6) begin
            check_val("imm_sel", int'(imm_sel), e_imm);
            check_val("sw_sel", int'(sw_sel), e_sws);
        end
        check_val("reg_we", int'(reg_we), rst ? 0 : e_we);
        check_val("stalled", int'(stalled), rst ? 0 : e_st);
        if (glitch) begin
            #2 sw8 = sw;
        end
        @(posedge clk);
        if (rst) begin
            m_pc        = 0;
            m_elapsed   = 0;
            sw_hist_old = 1'b0;
            sw_hist_new = 1'b0;
        end else begin
            if (e_st == 0) begin
                m_pc      = (m_pc == PROG_LEN - 1) ? 0 : m_pc + 1;
                m_elapsed = 0;
            end else if (op == 4 || op == 5) begin
                m_elapsed++;
            end
            sw_hist_old = sw_hist_new;
            sw_hist_new = sw;
        end
    endtask

    initial begin
        bit sw_lvl;
        bit did_rst;
        // Directed program: LDI ADDI WAIT1 ADD LDS MULI MUL WAIT0 ADD ADD
        prog[0] = 0; prog[1] = 3; prog[2] = 7; prog[3] = 2; prog[4] = 1;
        prog[5] = 5; prog[6] = 4; prog[7] = 6; prog[8] = 2; prog[9] = 2;
        m_pc = 0; m_elapsed = 0; sw_hist_old = 1'b0; sw_hist_new = 1'b0;
        reset  = 1'b1;
        sw8    = 1'b0;
        opcode = '0;
        repeat (2) @(posedge clk);

        // Reset state, then WAIT1 holds while the switch stays low.
        run_cycle(1'b1, 1'b0, 1'b0);
        repeat (12) run_cycle(1'b0, 1'b0, 1'b0);
        // Switch rises: release after the synchronizer latency, then
        // MULI/MUL stall, and WAIT0 holds while the switch is high.
        repeat (14) run_cycle(1'b0, 1'b1, 1'b0);
        // Sub-cycle glitches low on the switch must not release WAIT0.
        repeat (6) run_cycle(1'b0, 1'b1, 1'b1);
        repeat (8) run_cycle(1'b0, 1'b0, 1'b0);
        // Wrap past PROG_LEN-1 and reach the MULI again; reset it mid-way.
        did_rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (!did_rst && m_pc == 5 && m_elapsed == 1) begin
                did_rst = 1'b1;
                run_cycle(1'b1, 1'b0, 1'b0);
            end else begin
                run_cycle(1'b0, 1'b0, 1'b0);
            end
        end

        // Randomized programs, switch activity and occasional resets.
        sw_lvl = 1'b0;
        for (int p = 0; p < 20; p++) begin
            run_cycle(1'b1, sw_lvl, 1'b0);
            for (int k = 0; k < PROG_LEN; k++) prog[k] = int'($urandom_range(0, 7));
            for (int c = 0; c < 60; c++) begin
                if ($urandom_range(0, 3) == 0) sw_lvl = ~sw_lvl;
                run_cycle($urandom_range(0, 39) == 0, sw_lvl,
                          $urandom_range(0, 15) == 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Control stage for the picoMIPS core. Owns the program counter, which addresses the asynchronous-read program memory.
- Decodes the returned opcode into ALU function and datapath controls.
- Sequences stalls for the WAIT0/WAIT1 switch handshake and an optional multi-cycle multiply.
- Sits between program memory (upstream) and the register file / ALU (downstream).

Parameters:
P_SIZE, 4, program memory address width
O_SIZE, 3, opcode width
A_SIZE, 2, ALU function width
PROG_LEN, 16, number of program words; PC wraps after PROG_LEN-1 (1 <= PROG_LEN <= 2**P_SIZE)
MUL_CYCLES, 1, cycles a MUL/MULI occupies (1..8); 1 = single-cycle multiplier

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
opcode  in  O_SIZE  opcode of the instruction at pc (program memory output, same cycle)
sw8  in  1  raw SW8 switch level, asynchronous to clk
pc  out  P_SIZE  program counter / program memory address
alu_func  out  A_SIZE  ALU function: 00 A, 01 B, 10 ADD, 11 MUL
reg_we  out  1  register file write enable for the current cycle
imm_sel  out  1  1 = ALU B operand from instruction immediate, 0 = from register
sw_sel  out  1  1 = write-back data from switches (LDS)
stalled  out  1  1 = pc held this cycle (wait or multiply in progress)

Behaviour:
- One clock, synchronous active-high reset. Only state elements: pc, FSM state, multiply counter, 2-flop sw8 synchronizer.
- Reset (takes effect at the clk edge while reset=1):
  - pc=0, state=RUN, mul_cnt=0, both synchronizer flops=0.
  - While reset=1, reg_we=0 and stalled=0 regardless of opcode; alu_func, imm_sel and sw_sel still follow decode.
- sw8 synchronizer: sw8_s is sw8 delayed by two flops. Only sw8_s is used. A switch change is visible to the wait logic on the 2nd rising edge after the change.
- PC advance: next_pc = (pc == PROG_LEN-1) ? 0 : pc+1. PC advances on every edge where the current cycle is not stalled.
- Control outputs are combinational from (state, opcode, sw8_s, mul_cnt). pc is registered.
- Decode in state RUN:
  - LDI 000: alu_func=01, imm_sel=1, sw_sel=0, reg_we=1, advance.
  - LDS 001: alu_func=01, imm_sel=0, sw_sel=1, reg_we=1, advance.
  - ADD 010: alu_func=10, imm_sel=0, reg_we=1, advance.
  - ADDI 011: alu_func=10, imm_sel=1, reg_we=1, advance.
  - MUL 100 / MULI 101: alu_func=11, imm_sel = opcode[0].
    - MUL_CYCLES=1: reg_we=1, advance.
    - MUL_CYCLES>1: reg_we=0, stalled=1, pc held; next state MULT with mul_cnt=MUL_CYCLES-2.
  - WAIT0 110: alu_func=00, reg_we=0. If sw8_s==0, advance with stalled=0; else hold pc, stalled=1.
  - WAIT1 111: as WAIT0 with sw8_s==1 as the release condition.
- State MULT:
  - alu_func=11, imm_sel=opcode[0]; opcode is stable because pc is held.
  - mul_cnt>0: reg_we=0, stalled=1, mul_cnt decrements.
  - mul_cnt==0: reg_we=1, stalled=0, pc advances, state returns to RUN.
  - A MUL/MULI therefore occupies exactly MUL_CYCLES cycles with exactly one reg_we pulse, on its last cycle.
- Back-to-back MULs: each takes the full MUL_CYCLES; there is no overlap.
- Wrap-around: the instruction at PROG_LEN-1 that advances leads to pc=0 on the next cycle. No bubble.
- Reset during MULT: multiply aborts with no reg_we pulse; pc=0, state=RUN on the next cycle.
- Reset during WAIT: clears the stall; the synchronizer restarts from 0.
- Stalled cycles never assert reg_we. reg_we and stalled are never both 1.

Test Plan:
- Reset then LDI,ADDI,ADD,LDS at pc 0..3 (PROG_LEN=16) -> pc steps 0,1,2,3,4 on consecutive edges; alu_func 01,10,10,01; reg_we=1 each cycle; imm_sel 1,1,0,0; sw_sel only on LDS.
- WAIT1 at pc=2, sw8=0 for 10 cycles, then sw8=1 -> pc holds at 2 with stalled=1 and reg_we=0; pc becomes 3 on the 3rd edge after sw8 rises (2 sync edges + advance).
- MUL_CYCLES=3, MULI at pc=5 -> pc=5 for 3 cycles; reg_we 0,0,1; stalled 1,1,0; alu_func=11 and imm_sel=1 throughout; pc=6 after.
- PROG_LEN=10, all ADD -> pc sequence ...8,9,0,1 with no stall at wrap.
- MUL_CYCLES=4, assert reset for 1 cycle during the 2nd MUL cycle -> no reg_we pulse; pc=0, stalled=0 after reset; the next instruction decodes normally.
- WAIT0 with sw8 toggling 1->0->1 within one clock period -> no release (sw8_s never samples 0); pc held throughout.
